// File: rtl/instruction_fetch_responder.sv
// Fetch-side responder with a one-entry last-fetch buffer in front of a valid/ready memory read port.
// Buffer hits answer in the same cycle; misses issue a single read and answer from the buffer once it fills.
module instruction_fetch_responder #(
  parameter int ADDR_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        instruction_addr,
  input  logic                         instruction_fetch_activate,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_data,
  output logic                         instruction_fetch_done,
  input  logic                         invalidate,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  input  logic                         mem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_resp_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                       state_q;
  logic                         buf_valid_q;
  logic [ADDR_WIDTH-1:0]        buf_addr_q;
  logic [INSTRUCTION_WIDTH-1:0] buf_data_q;
  logic [ADDR_WIDTH-1:0]        req_addr_q;
  logic                         stale_q;

  logic hit;
  logic fill;

  assign hit = instruction_fetch_activate && buf_valid_q &&
               (buf_addr_q == instruction_addr) && !invalidate;

  assign instruction_fetch_done = hit;
  assign instruction_data       = hit ? buf_data_q : '0;

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = req_addr_q;

  // A response that raced an invalidate (now or earlier in WAIT) is dropped.
  assign fill = (state_q == WAIT) && mem_resp_valid && !stale_q && !invalidate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      req_addr_q  <= '0;
      stale_q     <= 1'b0;
    end else begin
      if (invalidate) begin
        buf_valid_q <= 1'b0;
      end else if (fill) begin
        buf_valid_q <= 1'b1;
      end

      if (fill) begin
        buf_addr_q <= req_addr_q;
        buf_data_q <= mem_resp_data;
      end

      unique case (state_q)
        IDLE: begin
          if (instruction_fetch_activate && !hit) begin
            req_addr_q <= instruction_addr;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // valid&&ready is a completed transfer, so it wins over dropping the
          // request; otherwise a late response could land on a later request.
          if (mem_req_ready) begin
            stale_q <= 1'b0;
            state_q <= WAIT;
          end else if (!instruction_fetch_activate || hit) begin
            state_q <= IDLE;
          end else begin
            req_addr_q <= instruction_addr;
          end
        end
        WAIT: begin
          if (invalidate) begin
            stale_q <= 1'b1;
          end
          if (mem_resp_valid) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Bench for instruction_fetch_responder: directed sequences, a hit/miss vector table,
// and random traffic checked against a transaction-level buffer/memory model.
module tb_instruction_fetch_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction_addr = '0;
  logic        instruction_fetch_activate = 1'b0;
  logic [31:0] instruction_data;
  logic        instruction_fetch_done;
  logic        invalidate = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  instruction_fetch_responder #(
    .ADDR_WIDTH(32),
    .INSTRUCTION_WIDTH(32)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .instruction_addr           (instruction_addr),
    .instruction_fetch_activate (instruction_fetch_activate),
    .instruction_data           (instruction_data),
    .instruction_fetch_done     (instruction_fetch_done),
    .invalidate                 (invalidate),
    .mem_req_valid              (mem_req_valid),
    .mem_req_ready              (mem_req_ready),
    .mem_req_addr               (mem_req_addr),
    .mem_resp_valid             (mem_resp_valid),
    .mem_resp_data              (mem_resp_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Behavioural memory: answers each accepted read exactly once after mem_lat cycles.
  int          mem_lat = 2;
  bit          spur_en = 1'b0;
  int          req_cnt = 0;
  int          vld_cycles = 0;
  logic [31:0] last_req_addr = '0;

  initial begin
    bit          pend;
    int          cnt;
    logic [31:0] pa;
    bit          acc;
    pend = 1'b0;
    cnt = 0;
    pa = '0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(posedge clk);
      acc = mem_req_valid && mem_req_ready;
      if (mem_req_valid) vld_cycles++;
      if (acc) begin
        req_cnt++;
        last_req_addr = mem_req_addr;
        pend = 1'b1;
        pa = mem_req_addr;
        cnt = spur_en ? int'($urandom_range(1, 4)) : mem_lat;
      end
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_data = '0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data = memfn(pa);
          pend = 1'b0;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = $urandom;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      @(negedge clk);
      if (instruction_fetch_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic        act;
    logic        inv;
    logic [31:0] addr;
    logic        exp_done;
    logic [31:0] exp_data;
    logic        exp_req;
    logic [31:0] exp_req_addr;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    int          base;
    int          vbase;
    bit          ok;
    bit          bv;
    logic [31:0] ba;
    logic [31:0] bd;
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_addr;
    logic        prev_act;
    logic [31:0] prev_addr;
    bit          exp_hit;
    int          run;

    // Buffer holds 0x100 when the table starts; memory is never ready during it.
    vecs[0] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'h0050_0093, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h104, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'h0050_0093, 1'b1, 32'h104};
    vecs[4] = '{1'b1, 1'b0, 32'h101, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h000, 1'b0, 32'h0,         1'b1, 32'h101};
    vecs[6] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h100, 1'b0, 32'h0,         1'b1, 32'h100};

    // Reset: outputs quiet even with a live fetch presented.
    rst = 1'b1;
    instruction_fetch_activate = 1'b1;
    instruction_addr = 32'h100;
    mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_done", instruction_fetch_done, 0);
    check("rst_data", instruction_data, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_addr", mem_req_addr, 0);
    tick();
    rst = 1'b0;

    // Cold miss: request in cycle 1, response in cycle 3, done in cycle 4.
    mem_lat = 2;
    base = req_cnt;
    vbase = vld_cycles;
    @(negedge clk);
    check("cold_c0_req", mem_req_valid, 0);
    check("cold_c0_done", instruction_fetch_done, 0);
    tick(); @(negedge clk);
    check("cold_c1_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h100});
    tick(); @(negedge clk);
    check("cold_c2_req", mem_req_valid, 0);
    check("cold_c2_done", instruction_fetch_done, 0);
    tick(); @(negedge clk);
    check("cold_c3_done", instruction_fetch_done, 0);
    tick(); @(negedge clk);
    check("cold_c4_done", {instruction_fetch_done, instruction_data}, {1'b1, 32'h0050_0093});
    check("cold_req_count", req_cnt - base, 1);
    check("cold_vld_cycles", vld_cycles - vbase, 1);

    // Stalled fetch stage re-presents the PC: served from the buffer.
    for (int i = 0; i < 10; i++) begin
      tick(); @(negedge clk);
      check("stall_hit", {instruction_fetch_done, instruction_data}, {1'b1, 32'h0050_0093});
    end
    check("stall_req_count", req_cnt - base, 1);
    check("stall_vld_cycles", vld_cycles - vbase, 1);

    // Hit/miss vector table.
    for (int i = 0; i < 8; i++) begin
      tick();
      mem_req_ready = 1'b0;
      instruction_fetch_activate = vecs[i].act;
      invalidate = vecs[i].inv;
      instruction_addr = vecs[i].addr;
      @(negedge clk);
      check($sformatf("vec%0d_done", i), instruction_fetch_done, vecs[i].exp_done);
      check($sformatf("vec%0d_data", i), instruction_data, vecs[i].exp_data);
      check($sformatf("vec%0d_req", i), mem_req_valid, vecs[i].exp_req);
      if (vecs[i].exp_req) check($sformatf("vec%0d_req_addr", i), mem_req_addr, vecs[i].exp_req_addr);
    end
    tick();
    instruction_fetch_activate = 1'b0;
    invalidate = 1'b0;
    tick();

    // Backpressure retarget: only the address present at acceptance is requested.
    mem_lat = 2;
    base = req_cnt;
    tick();
    instruction_fetch_activate = 1'b1;
    instruction_addr = 32'h104;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("bp_c0_req", mem_req_valid, 0);
    tick();
    instruction_addr = 32'h108;
    @(negedge clk);
    check("bp_c1_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h104});
    tick(); @(negedge clk);
    check("bp_c2_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h108});
    tick();
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("bp_c3_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h108});
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("bp_c4_req", mem_req_valid, 0);
    check("bp_req_count", req_cnt - base, 1);
    check("bp_req_addr", last_req_addr, 32'h108);
    wait_done(20, ok);
    check("bp_done_seen", ok, 1);
    check("bp_data", instruction_data, memfn(32'h108));

    // Redirect while a read is outstanding.
    mem_lat = 3;
    base = req_cnt;
    tick();
    instruction_addr = 32'h200;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("rd_c0_req", mem_req_valid, 0);
    tick(); @(negedge clk);
    check("rd_c1_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h200});
    tick();
    instruction_addr = 32'h300;
    @(negedge clk);
    check("rd_c2", {instruction_fetch_done, mem_req_valid}, 2'b00);
    tick(); @(negedge clk);
    check("rd_c3_done", instruction_fetch_done, 0);
    tick(); @(negedge clk);
    check("rd_c4_done", instruction_fetch_done, 0);
    tick(); @(negedge clk);
    check("rd_c5", {instruction_fetch_done, mem_req_valid}, 2'b00);
    tick();
    instruction_addr = 32'h200;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("rd_c6_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h300});
    check("rd_c6_old_hit", {instruction_fetch_done, instruction_data}, {1'b1, memfn(32'h200)});
    tick();
    instruction_addr = 32'h300;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("rd_c7", {instruction_fetch_done, mem_req_valid}, 2'b00);
    tick(); @(negedge clk);
    check("rd_c8_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h300});
    wait_done(20, ok);
    check("rd_done_seen", ok, 1);
    check("rd_data", instruction_data, memfn(32'h300));
    check("rd_req_count", req_cnt - base, 2);
    check("rd_req_addr", last_req_addr, 32'h300);

    // Invalidate against a buffered hit.
    base = req_cnt;
    tick();
    invalidate = 1'b1;
    @(negedge clk);
    check("inv_same_cycle", {instruction_fetch_done, instruction_data}, {1'b0, 32'h0});
    tick();
    invalidate = 1'b0;
    @(negedge clk);
    check("inv_next_done", instruction_fetch_done, 0);
    check("inv_refetch_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h300});
    wait_done(20, ok);
    check("inv_done_seen", ok, 1);
    check("inv_data", instruction_data, memfn(32'h300));
    check("inv_req_count", req_cnt - base, 1);

    // Invalidate while the read is outstanding: response dropped, address refetched.
    mem_lat = 3;
    base = req_cnt;
    tick();
    instruction_addr = 32'h400;
    tick(); @(negedge clk);
    check("invw_c1_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h400});
    tick();
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    tick(); @(negedge clk);
    check("invw_c4_done", instruction_fetch_done, 0);
    tick(); @(negedge clk);
    check("invw_c5", {instruction_fetch_done, mem_req_valid}, 2'b00);
    tick(); @(negedge clk);
    check("invw_c6_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h400});
    wait_done(20, ok);
    check("invw_done_seen", ok, 1);
    check("invw_data", instruction_data, memfn(32'h400));
    check("invw_req_count", req_cnt - base, 2);

    // Asynchronous reset while waiting; the late response must be ignored.
    mem_lat = 6;
    tick();
    instruction_addr = 32'h500;
    mem_req_ready = 1'b1;
    tick();
    tick();
    instruction_addr = 32'h400;
    #2 rst = 1'b1;
    @(negedge clk);
    check("arst_done", {instruction_fetch_done, instruction_data}, {1'b0, 32'h0});
    check("arst_req", {mem_req_valid, mem_req_addr}, {1'b0, 32'h0});
    tick();
    instruction_fetch_activate = 1'b0;
    mem_req_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    instruction_fetch_activate = 1'b1;
    instruction_addr = 32'h500;
    @(negedge clk);
    check("arst_resp_ignored", {instruction_fetch_done, mem_req_valid}, 2'b00);
    tick();
    mem_lat = 2;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("arst_reissue", {mem_req_valid, mem_req_addr}, {1'b1, 32'h500});
    wait_done(20, ok);
    check("arst_done_seen", ok, 1);
    check("arst_data", instruction_data, memfn(32'h500));

    // Random traffic against a transaction-level model.
    tick();
    instruction_fetch_activate = 1'b0;
    mem_req_ready = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    spur_en = 1'b1;
    bv = 1'b0; ba = '0; bd = '0;
    m_out = 1'b0; m_stale = 1'b0; m_addr = '0;
    prev_act = 1'b0; prev_addr = '0;
    run = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if ($urandom_range(0, 7) == 0) instruction_addr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      instruction_fetch_activate = ($urandom_range(0, 15) != 0);
      invalidate = ($urandom_range(0, 19) == 0);
      mem_req_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);

      exp_hit = instruction_fetch_activate && bv && (ba == instruction_addr) && !invalidate;
      check("rnd_done", instruction_fetch_done, exp_hit);
      check("rnd_data", instruction_data, exp_hit ? bd : 32'h0);
      if (mem_req_valid) begin
        check("rnd_req_tracks_fetch", {prev_act, prev_addr}, {1'b1, mem_req_addr});
        check("rnd_one_outstanding", m_out, 0);
      end

      if (!instruction_fetch_activate || invalidate || instruction_addr != prev_addr ||
          !prev_act || instruction_fetch_done) run = 0;
      else run++;
      check("rnd_liveness", run > 40, 0);

      if (mem_resp_valid && m_out) begin
        if (!m_stale && !invalidate) begin
          bv = 1'b1; ba = m_addr; bd = memfn(m_addr);
        end
        m_out = 1'b0;
      end
      if (invalidate) begin
        bv = 1'b0;
        if (m_out) m_stale = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        m_out = 1'b1; m_addr = mem_req_addr; m_stale = 1'b0;
      end
      prev_act = instruction_fetch_activate;
      prev_addr = instruction_addr;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation still running at t=%0t, required completion earlier", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
